// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if -- data-memory request/response bus between the MEM stage and
// the data memory.
//
// Signals:
//   dm_req    master->slave  request valid
//   dm_we     master->slave  1 = store, 0 = load
//   dm_addr   master->slave  byte address
//   dm_wdata  master->slave  store data
//   dm_gnt    slave->master  request accepted this cycle
//   dm_rvalid slave->master  load data valid
//   dm_rdata  slave->master  load data
// ---------------------------------------------------------------------------
interface mem_stage_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt;
    logic        dm_rvalid;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_gnt, dm_rvalid, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_gnt, dm_rvalid, dm_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage -- pipeline MEM stage. Passes ALU results to MEM/WB, issues word
// loads/stores on the data-memory bus and stalls upstream until the access
// completes.
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   mem_rd_addr/we/data  destination register info from EX/MEM
//   mem_mem_addr    load/store byte address
//   mem_alu_op      operation code (ALU_OP_LW / ALU_OP_SW select memory)
//   mem_op_2        store data
//   dm              data-memory bus (master side)
//   stall           combinational; upstream holds while high
//   wb_rd_addr/we/data  registered MEM/WB write-back
//   misalign_err    registered one-cycle misaligned-access flag
//
// Build option: define MEM_ALIGN_CHECK_EN to reject word accesses whose
// address is not 4-byte aligned (no bus request, completes as a bubble and
// pulses misalign_err). Without it the address passes through unchanged and
// misalign_err is tied low.
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter logic [3:0] ALU_OP_LW = 4'd10,
    parameter logic [3:0] ALU_OP_SW = 4'd11
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  mem_rd_addr,
    input  logic        mem_rd_we,
    input  logic [31:0] mem_rd_data,
    input  logic [31:0] mem_mem_addr,
    input  logic [3:0]  mem_alu_op,
    input  logic [31:0] mem_op_2,
    mem_stage_if.master dm,
    output logic        stall,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_rd_we,
    output logic [31:0] wb_rd_data,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // no access in flight
        REQ  = 2'd1,  // request outstanding, not yet granted
        RESP = 2'd2   // load granted, waiting for read data
    } state_t;

    state_t state, state_next;

    logic is_lw, is_sw, is_mem;
    logic misaligned;
    logic done;  // current upstream op retires at this edge

    assign is_lw  = (mem_alu_op == ALU_OP_LW);
    assign is_sw  = (mem_alu_op == ALU_OP_SW);
    assign is_mem = is_lw | is_sw;

`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = is_mem & (mem_mem_addr[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // NOTE: every output of this block gets a default before the case so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next  = state;
        done        = 1'b0;
        dm.dm_req   = 1'b0;
        dm.dm_we    = is_sw;
        dm.dm_addr  = mem_mem_addr;
        dm.dm_wdata = mem_op_2;

        case (state)
            IDLE, REQ: begin
                if (is_mem && !misaligned) begin
                    // Upstream is held while stalled, so the request fields
                    // stay stable across REQ cycles without local capture.
                    dm.dm_req = 1'b1;
                    if (dm.dm_gnt) begin
                        if (is_sw) begin
                            done       = 1'b1;
                            state_next = IDLE;
                        end else begin
                            state_next = RESP;
                        end
                    end else begin
                        state_next = REQ;
                    end
                end else begin
                    // Non-memory op or rejected misaligned access: one cycle.
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            RESP: begin
                // rvalid is only meaningful here; a response that arrives
                // with the grant is ignored because we are not yet in RESP.
                if (dm.dm_rvalid) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        stall = ~done;

        if (reset) begin
            dm.dm_req = 1'b0;
            stall     = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            wb_rd_addr <= 5'd0;
            wb_rd_we   <= 1'b0;
            wb_rd_data <= 32'd0;
        end else begin
            state <= state_next;
            if (!done) begin
                wb_rd_we <= 1'b0;  // bubble while stalled
            end else if (state == RESP) begin
                wb_rd_addr <= mem_rd_addr;
                wb_rd_we   <= mem_rd_we;
                wb_rd_data <= dm.dm_rdata;
            end else if (misaligned || is_sw) begin
                wb_rd_we <= 1'b0;
            end else begin
                wb_rd_addr <= mem_rd_addr;
                wb_rd_we   <= mem_rd_we;
                wb_rd_data <= mem_rd_data;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= done & misaligned & (state != RESP);
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage: reset checks, a table of
// single-cycle vectors, directed multi-cycle sequences and a randomized run
// compared against a transaction-level latency/write-back model.
// ---------------------------------------------------------------------------
module tb_mem_stage;
    localparam logic [3:0] OP_LW = 4'd10;
    localparam logic [3:0] OP_SW = 4'd11;
`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  mem_rd_addr;
    logic        mem_rd_we;
    logic [31:0] mem_rd_data;
    logic [31:0] mem_mem_addr;
    logic [3:0]  mem_alu_op;
    logic [31:0] mem_op_2;
    logic        stall;
    logic [4:0]  wb_rd_addr;
    logic        wb_rd_we;
    logic [31:0] wb_rd_data;
    logic        misalign_err;

    mem_stage_if dm_bus ();

    mem_stage dut (
        .clk          (clk),
        .reset        (reset),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_we    (mem_rd_we),
        .mem_rd_data  (mem_rd_data),
        .mem_mem_addr (mem_mem_addr),
        .mem_alu_op   (mem_alu_op),
        .mem_op_2     (mem_op_2),
        .dm           (dm_bus.master),
        .stall        (stall),
        .wb_rd_addr   (wb_rd_addr),
        .wb_rd_we     (wb_rd_we),
        .wb_rd_data   (wb_rd_data),
        .misalign_err (misalign_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
    endtask

    // Inputs change 1 ns after the rising edge; combinational outputs are
    // sampled 2 ns later, registered outputs 1 ns after the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive_op(input logic [3:0] op, input logic [4:0] rd, input logic we,
                            input logic [31:0] data, input logic [31:0] addr,
                            input logic [31:0] op2);
        mem_alu_op   = op;
        mem_rd_addr  = rd;
        mem_rd_we    = we;
        mem_rd_data  = data;
        mem_mem_addr = addr;
        mem_op_2     = op2;
    endtask

    task automatic bus(input logic gnt, input logic rvalid, input logic [31:0] rdata);
        dm_bus.dm_gnt    = gnt;
        dm_bus.dm_rvalid = rvalid;
        dm_bus.dm_rdata  = rdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive_op(4'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
        logic [31:0] addr;
        logic [31:0] op2;
        logic        gnt;
        logic        exp_req;
        logic        exp_stall;
        logic        exp_wb_we;
        logic [4:0]  exp_wb_addr;
        logic [31:0] exp_wb_data;
    } vec_t;

    vec_t vecs[6];

    // Randomized-run variables (single process only).
    int          kind, d, e, comp;
    logic        mis, mem_go, is_mem;
    logic [3:0]  r_op;
    logic [4:0]  r_rd;
    logic        r_we, exp_we;
    logic [31:0] r_data, r_addr, r_op2, r_ld;

    initial begin
        //            op     rd     we    data          addr          op2           gnt  req  stl  wbwe wbaddr wbdata
        vecs[0] = '{4'd0,  5'd5,  1'b1, 32'h0000_1234, 32'h0,        32'h0,        1'b0,1'b0,1'b0,1'b1,5'd5,  32'h0000_1234};
        vecs[1] = '{4'd3,  5'd31, 1'b1, 32'hFFFF_FFFF, 32'h4,        32'h0,        1'b0,1'b0,1'b0,1'b1,5'd31, 32'hFFFF_FFFF};
        vecs[2] = '{4'd0,  5'd0,  1'b0, 32'h0000_AAAA, 32'h8,        32'h0,        1'b0,1'b0,1'b0,1'b0,5'd0,  32'h0};
        vecs[3] = '{4'd9,  5'd9,  1'b1, 32'h5555_0000, 32'h10,       32'h0,        1'b1,1'b0,1'b0,1'b1,5'd9,  32'h5555_0000};
        vecs[4] = '{OP_SW, 5'd3,  1'b1, 32'h0000_0077, 32'h0000_0200,32'h0000_0011,1'b1,1'b1,1'b0,1'b0,5'd0,  32'h0};
        vecs[5] = '{4'd15, 5'd1,  1'b1, 32'h8000_0001, 32'h20,       32'h0,        1'b0,1'b0,1'b0,1'b1,5'd1,  32'h8000_0001};

        // ---------------- reset behaviour ----------------
        reset = 1'b1;
        drive_op(OP_LW, 5'd4, 1'b1, 32'h1, 32'h40, 32'h0);
        bus(1'b0, 1'b0, 32'd0);
        settle();
        check("reset_dm_req", dm_bus.dm_req, 1'b0);
        check("reset_stall", stall, 1'b0);
        tick();
        check("reset_wb_addr", wb_rd_addr, 5'd0);
        check("reset_wb_we", wb_rd_we, 1'b0);
        check("reset_wb_data", wb_rd_data, 32'd0);
        check("reset_misalign", misalign_err, 1'b0);
        do_reset();

        // ---------------- table vectors (single-cycle ops from IDLE) ----------------
        for (int i = 0; i < 6; i++) begin
            drive_op(vecs[i].op, vecs[i].rd, vecs[i].we, vecs[i].data, vecs[i].addr, vecs[i].op2);
            bus(vecs[i].gnt, 1'b0, 32'd0);
            settle();
            check($sformatf("vec%0d_req", i), dm_bus.dm_req, vecs[i].exp_req);
            check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            if (vecs[i].exp_req) begin
                check($sformatf("vec%0d_dm_we", i), dm_bus.dm_we, vecs[i].op == OP_SW);
                check($sformatf("vec%0d_dm_addr", i), dm_bus.dm_addr, vecs[i].addr);
                check($sformatf("vec%0d_dm_wdata", i), dm_bus.dm_wdata, vecs[i].op2);
            end
            tick();
            check($sformatf("vec%0d_wb_we", i), wb_rd_we, vecs[i].exp_wb_we);
            if (vecs[i].exp_wb_we) begin
                check($sformatf("vec%0d_wb_addr", i), wb_rd_addr, vecs[i].exp_wb_addr);
                check($sformatf("vec%0d_wb_data", i), wb_rd_data, vecs[i].exp_wb_data);
            end
        end

        // ---------------- SW with grant delayed 2 cycles ----------------
        do_reset();
        drive_op(OP_SW, 5'd2, 1'b1, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF);
        for (int c = 0; c < 3; c++) begin
            bus(c == 2, 1'b0, 32'd0);
            settle();
            check($sformatf("sw_c%0d_req", c), dm_bus.dm_req, 1'b1);
            check($sformatf("sw_c%0d_we", c), dm_bus.dm_we, 1'b1);
            check($sformatf("sw_c%0d_addr", c), dm_bus.dm_addr, 32'h0000_0100);
            check($sformatf("sw_c%0d_wdata", c), dm_bus.dm_wdata, 32'hDEAD_BEEF);
            check($sformatf("sw_c%0d_stall", c), stall, c != 2);
            tick();
            check($sformatf("sw_c%0d_wb_we", c), wb_rd_we, 1'b0);
        end
        drive_op(4'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        bus(1'b0, 1'b0, 32'd0);
        settle();
        check("sw_after_req", dm_bus.dm_req, 1'b0);

        // ---------------- LW, grant same cycle, rvalid 3 cycles later ----------------
        do_reset();
        drive_op(OP_LW, 5'd7, 1'b1, 32'h0, 32'h0000_0040, 32'h0);
        for (int c = 0; c < 4; c++) begin
            // rvalid with the grant carries junk that must be ignored
            if (c == 0)      bus(1'b1, 1'b1, 32'h1111_2222);
            else if (c == 3) bus(1'b0, 1'b1, 32'hCAFE_F00D);
            else             bus(1'b0, 1'b0, 32'h0);
            settle();
            check($sformatf("lw_c%0d_req", c), dm_bus.dm_req, c == 0);
            check($sformatf("lw_c%0d_stall", c), stall, c != 3);
            tick();
            if (c != 3) check($sformatf("lw_c%0d_wb_we", c), wb_rd_we, 1'b0);
        end
        check("lw_wb_addr", wb_rd_addr, 5'd7);
        check("lw_wb_we", wb_rd_we, 1'b1);
        check("lw_wb_data", wb_rd_data, 32'hCAFE_F00D);

        // ---------------- LW then ALU op back-to-back, zero-wait ----------------
        do_reset();
        drive_op(OP_LW, 5'd12, 1'b1, 32'h0, 32'h0000_0080, 32'h0);
        bus(1'b1, 1'b0, 32'h0);
        settle();
        check("b2b_lw_stall0", stall, 1'b1);
        tick();
        bus(1'b0, 1'b1, 32'h0BAD_F00D);
        settle();
        check("b2b_lw_stall1", stall, 1'b0);
        tick();
        check("b2b_lw_wb_data", wb_rd_data, 32'h0BAD_F00D);
        check("b2b_lw_wb_addr", wb_rd_addr, 5'd12);
        drive_op(4'd1, 5'd13, 1'b1, 32'h0000_ABCD, 32'h0, 32'h0);
        bus(1'b0, 1'b0, 32'h0);
        settle();
        check("b2b_alu_stall", stall, 1'b0);
        tick();
        check("b2b_alu_wb_we", wb_rd_we, 1'b1);
        check("b2b_alu_wb_addr", wb_rd_addr, 5'd13);
        check("b2b_alu_wb_data", wb_rd_data, 32'h0000_ABCD);

        // ---------------- reset while in RESP, then stray rvalid ----------------
        do_reset();
        drive_op(OP_LW, 5'd9, 1'b1, 32'h0, 32'h0000_00C0, 32'h0);
        bus(1'b1, 1'b0, 32'h0);
        tick();
        reset = 1'b1;
        bus(1'b0, 1'b0, 32'h0);
        settle();
        check("rst_resp_req", dm_bus.dm_req, 1'b0);
        check("rst_resp_stall", stall, 1'b0);
        tick();
        reset = 1'b0;
        check("rst_resp_wb_we", wb_rd_we, 1'b0);
        // LW still upstream, no grant, stray rvalid: an IDLE FSM requests
        // again and stalls instead of completing on the rvalid.
        bus(1'b0, 1'b1, 32'h5A5A_5A5A);
        settle();
        check("rst_idle_req", dm_bus.dm_req, 1'b1);
        check("rst_idle_stall", stall, 1'b1);
        tick();
        check("rst_no_wb", wb_rd_we, 1'b0);

        // ---------------- misaligned LW ----------------
        do_reset();
        drive_op(OP_LW, 5'd6, 1'b1, 32'h0, 32'h0000_0102, 32'h0);
        bus(1'b0, 1'b0, 32'h0);
        settle();
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_req", dm_bus.dm_req, 1'b0);
        check("mis_stall", stall, 1'b0);
        tick();
        check("mis_err", misalign_err, 1'b1);
        check("mis_wb_we", wb_rd_we, 1'b0);
        drive_op(4'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0);
        tick();
        check("mis_err_pulse", misalign_err, 1'b0);
`else
        check("mis_req", dm_bus.dm_req, 1'b1);
        check("mis_addr", dm_bus.dm_addr, 32'h0000_0102);
        check("mis_stall", stall, 1'b1);
        tick();
        check("mis_err", misalign_err, 1'b0);
`endif

        // ---------------- randomized run against a latency model ----------------
        // Each op retires after a number of cycles fixed by the access type:
        // ALU op or rejected access 1, SW (grant delay d) d+1, LW d+e+1.
        do_reset();
        for (int n = 0; n < 200; n++) begin
            kind = int'($urandom_range(0, 2));
            if (kind == 0) begin
                do r_op = 4'($urandom_range(0, 15));
                while (r_op == OP_LW || r_op == OP_SW);
            end else begin
                r_op = (kind == 1) ? OP_LW : OP_SW;
            end
            r_addr = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) r_addr[1:0] = 2'($urandom_range(1, 3));
            r_rd   = 5'($urandom);
            r_we   = 1'($urandom);
            r_data = $urandom;
            r_op2  = $urandom;
            r_ld   = $urandom;
            d      = int'($urandom_range(0, 3));
            e      = int'($urandom_range(1, 3));
            is_mem = (kind != 0);
            mis    = (r_addr[1:0] != 2'b00);
            mem_go = is_mem && !(ALIGN_EN && mis);
            comp   = !mem_go ? 0 : ((kind == 1) ? d + e : d);
            drive_op(r_op, r_rd, r_we, r_data, r_addr, r_op2);
            for (int c = 0; c <= comp; c++) begin
                bus(mem_go && c == d,
                    (mem_go && kind == 1 && c == comp) || (c <= d && $urandom_range(0, 3) == 0),
                    (c == comp) ? r_ld : $urandom);
                settle();
                check($sformatf("rnd%0d_c%0d_stall", n, c), stall, c != comp);
                check($sformatf("rnd%0d_c%0d_req", n, c), dm_bus.dm_req, mem_go && c <= d);
                if (mem_go && c <= d) begin
                    check($sformatf("rnd%0d_dm_we", n), dm_bus.dm_we, kind == 2);
                    check($sformatf("rnd%0d_dm_addr", n), dm_bus.dm_addr, r_addr);
                    check($sformatf("rnd%0d_dm_wdata", n), dm_bus.dm_wdata, r_op2);
                end
                tick();
                if (c == comp) begin
                    exp_we = (kind == 2 || !mem_go && is_mem) ? 1'b0 : r_we;
                    check($sformatf("rnd%0d_wb_we", n), wb_rd_we, exp_we);
                    if (exp_we) begin
                        check($sformatf("rnd%0d_wb_addr", n), wb_rd_addr, r_rd);
                        check($sformatf("rnd%0d_wb_data", n), wb_rd_data, (kind == 1) ? r_ld : r_data);
                    end
                    check($sformatf("rnd%0d_misalign", n), misalign_err, is_mem && !mem_go);
                end else begin
                    check($sformatf("rnd%0d_c%0d_bubble", n, c), wb_rd_we, 1'b0);
                    check($sformatf("rnd%0d_c%0d_misalign", n, c), misalign_err, 1'b0);
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
- REQ-001 Parameter: ALU_OP_LW, 4'd10, mem_alu_op code for a word load.
- REQ-002 Parameter: ALU_OP_SW, 4'd11, mem_alu_op code for a word store.
- REQ-003 clk  in  1  rising-edge clock.
- REQ-004 reset  in  1  synchronous, active-high.
- REQ-005 mem_rd_addr  in  5  destination register from EX/MEM.
- REQ-006 mem_rd_we  in  1  destination write enable from EX/MEM.
- REQ-007 mem_rd_data  in  32  ALU result from EX/MEM.
- REQ-008 mem_mem_addr  in  32  load/store byte address.
- REQ-009 mem_alu_op  in  4  operation code; LW/SW select a memory access.
- REQ-010 mem_op_2  in  32  store data.
- REQ-011 dm_req  out  1  data-memory request.
- REQ-012 dm_we  out  1  1 = store, 0 = load.
- REQ-013 dm_addr  out  32  request address.
- REQ-014 dm_wdata  out  32  store data.
- REQ-015 dm_gnt  in  1  request accepted this cycle.
- REQ-016 dm_rvalid  in  1  load data valid.
- REQ-017 dm_rdata  in  32  load data.
- REQ-018 stall  out  1  combinational; upstream EX/MEM and earlier stages SHALL hold while high.
- REQ-019 wb_rd_addr  out  5  registered MEM/WB destination.
- REQ-020 wb_rd_we  out  1  registered MEM/WB write enable.
- REQ-021 wb_rd_data  out  32  registered MEM/WB write data.
- REQ-022 misalign_err  out  1  registered one-cycle misalignment flag.

Function
- REQ-023 The FSM SHALL have three states: IDLE, REQ (request outstanding, no grant yet) and RESP (load granted, awaiting data).
- REQ-024 A non-memory op in IDLE SHALL load wb_* from mem_rd_* at the next edge, with 1-cycle latency and stall=0.
- REQ-025 In IDLE with LW/SW, dm_req SHALL be 1 in the same cycle, with dm_we=(op==SW), dm_addr=mem_mem_addr and dm_wdata=mem_op_2.
- REQ-026 In REQ, dm_req SHALL stay 1 with unchanged fields until dm_gnt=1.
- REQ-027 Transitions:
  - SW granted: complete, go to IDLE.
  - LW granted: go to RESP.
  - No grant: go to (or stay in) REQ.
- REQ-028 In RESP, dm_req SHALL be 0; dm_rvalid=1 SHALL complete the load and return to IDLE.
- REQ-029 dm_rvalid SHALL be ignored outside RESP, including an rvalid in the same cycle as the grant.
- REQ-030 stall SHALL be 1 whenever a LW/SW is present and does not complete in the current cycle.
- REQ-031 Load completion SHALL write wb_rd_data=dm_rdata, wb_rd_addr=mem_rd_addr and wb_rd_we=mem_rd_we.
- REQ-032 Store completion SHALL write wb_rd_we=0.
- REQ-033 In every stalled cycle, wb_rd_we SHALL be written 0 (bubble); wb_rd_addr and wb_rd_data are don't-care.
- REQ-034 After a completion, the next cycle SHALL accept the new upstream op from IDLE with no dead cycle.

Reset
- REQ-035 When reset=1 at a clock edge: state=IDLE, wb_rd_addr=0, wb_rd_we=0, wb_rd_data=0, misalign_err=0.
- REQ-036 While reset=1, dm_req and stall SHALL be 0.
- REQ-037 Reset in REQ or RESP SHALL abandon the access; a later dm_rvalid SHALL be ignored.

Configuration
- REQ-038 Macro MEM_ALIGN_CHECK_EN defined:
  - LW/SW with mem_mem_addr[1:0]!=0 SHALL raise no dm_req and complete in 1 cycle.
  - That completion SHALL write wb_rd_we=0 and pulse misalign_err=1 for one cycle.
- REQ-039 Macro MEM_ALIGN_CHECK_EN undefined:
  - No alignment check; the address SHALL pass through unchanged.
  - misalign_err SHALL be tied to 0.

Verification
- REQ-040 Non-memory op, rd=5, we=1, data=0x1234: wb outputs match one cycle later; stall=0; dm_req=0.
- REQ-041 SW addr=0x100, op_2=0xDEADBEEF, dm_gnt delayed 2 cycles:
  - dm_req held 3 cycles with stable fields; stall=1 for 2 cycles.
  - wb_rd_we=0 throughout.
- REQ-042 LW rd=7, addr=0x40, gnt same cycle, rvalid 3 cycles later with 0xCAFEF00D:
  - stall=1 for 3 cycles.
  - Then wb_rd_addr=7, wb_rd_we=1, wb_rd_data=0xCAFEF00D.
- REQ-043 LW then ALU op back-to-back, zero-wait memory (gnt immediate, rvalid next cycle): ALU result appears in wb the cycle after the load result.
- REQ-044 Reset asserted in RESP, then rvalid pulsed: state returns to IDLE; wb_rd_we stays 0; no write-back.
- REQ-045 With MEM_ALIGN_CHECK_EN, LW addr=0x102: no dm_req; misalign_err=1 for one cycle; wb_rd_we=0; stall=0.
